// File: rtl/mix_col_pkg.sv
// Shared GF(2^8) helpers and FSM state encoding for the MixColumns engine.
// The inverse datapath in the engine is compiled only when
// MIX_COL_ENGINE_INV_EN is defined.
package mix_col_pkg;

    // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0] GF_POLY = 8'h1b;

    // State | meaning
    // IDLE  | waiting for a block, in_ready high
    // RUN   | transforming COLS_PER_CYC columns per edge
    // DONE  | result held until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by x (i.e. by 02) modulo the field polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // General shift-and-add field multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] m;
        p = 8'h00;
        x = a;
        m = b;
        for (int i = 0; i < 8; i++) begin
            if (m[0]) p = p ^ x;
            x = xtime(x);
            m = m >> 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/mix_col_unit.sv
// Combinational transform of one 32-bit state column. Byte 0 sits in the
// top bits of the column word. The inverse matrix is built only when
// MIX_COL_ENGINE_INV_EN is defined; otherwise inv is ignored.
module mix_col_unit
    import mix_col_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] fwd_col;

    function automatic logic [7:0] fwd_row(input logic [7:0] x0, input logic [7:0] x1,
                                           input logic [7:0] x2, input logic [7:0] x3);
        return xtime(x0) ^ xtime(x1) ^ x1 ^ x2 ^ x3;
    endfunction

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign fwd_col = {fwd_row(a0, a1, a2, a3), fwd_row(a1, a2, a3, a0),
                      fwd_row(a2, a3, a0, a1), fwd_row(a3, a0, a1, a2)};

`ifdef MIX_COL_ENGINE_INV_EN
    logic [31:0] inv_col;

    function automatic logic [7:0] inv_row(input logic [7:0] x0, input logic [7:0] x1,
                                           input logic [7:0] x2, input logic [7:0] x3);
        return gf_mul(x0, 8'h0e) ^ gf_mul(x1, 8'h0b) ^ gf_mul(x2, 8'h0d) ^ gf_mul(x3, 8'h09);
    endfunction

    assign inv_col = {inv_row(a0, a1, a2, a3), inv_row(a1, a2, a3, a0),
                      inv_row(a2, a3, a0, a1), inv_row(a3, a0, a1, a2)};

    // Select forward or inverse result.
    always_comb begin
        col_out = fwd_col;
        if (inv) col_out = inv_col;
    end
`else
    logic unused_inv;
    assign unused_inv = inv;

    // Forward-only build.
    always_comb begin
        col_out = fwd_col;
    end
`endif

endmodule

// File: rtl/mix_col_engine.sv
// Block-level MixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYC columns per clock in place, then holds the result until the
// consumer takes it. InvMixColumns support is compiled in only when
// MIX_COL_ENGINE_INV_EN is defined.
module mix_col_engine
    import mix_col_pkg::*;
#(
    parameter int COLS_PER_CYC = 1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NSTEP = 4 / COLS_PER_CYC;

    state_t      state;
    logic [1:0]  step;
    logic [31:0] cols_q  [4];
    logic [31:0] col_res [COLS_PER_CYC];
    logic [1:0]  col_idx [COLS_PER_CYC];
    logic        unit_inv;

`ifdef MIX_COL_ENGINE_INV_EN
    logic inv_q;
    assign unit_inv = inv_q;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign unit_inv      = 1'b0;
`endif

    // One column unit per column handled in a step.
    for (genvar k = 0; k < COLS_PER_CYC; k++) begin : g_col
        assign col_idx[k] = 2'((int'(step) * COLS_PER_CYC) + k);

        mix_col_unit u_unit (
            .col_in  (cols_q[col_idx[k]]),
            .inv     (unit_inv),
            .col_out (col_res[k])
        );
    end

    // Column 0 occupies the most significant word of the bus.
    assign out_data = {cols_q[0], cols_q[1], cols_q[2], cols_q[3]};

    // Handshake FSM with in-place column update and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 2'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            for (int c = 0; c < 4; c++) cols_q[c] <= 32'h0;
`ifdef MIX_COL_ENGINE_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cols_q[0] <= in_data[127:96];
                        cols_q[1] <= in_data[95:64];
                        cols_q[2] <= in_data[63:32];
                        cols_q[3] <= in_data[31:0];
`ifdef MIX_COL_ENGINE_INV_EN
                        inv_q     <= in_inv;
`endif
                        step      <= 2'd0;
                        state     <= RUN;
                        busy      <= 1'b1;
                        in_ready  <= 1'b0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < COLS_PER_CYC; k++) cols_q[col_idx[k]] <= col_res[k];
                    if (step == 2'(NSTEP - 1)) begin
                        step      <= 2'd0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_col_engine.sv
// Directed bench for mix_col_engine with COLS_PER_CYC = 1, 2 and 4 side by
// side. Inverse-mode checks depend on MIX_COL_ENGINE_INV_EN.
module tb_mix_col_engine;

    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_d4d4d4d5_c6c6c6c6;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_d5d5d7d6_c6c6c6c6;
    localparam logic [127:0] V2_IN   = 128'h01010101_c6c6c6c6_2d26314c_d4d4d4d5;
    localparam logic [127:0] V2_OUT  = 128'h01010101_c6c6c6c6_4d7ebdf8_d5d5d7d6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         in_inv    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_col_engine #(.COLS_PER_CYC(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a block for one edge; returns #1 after the accepting edge.
    task automatic start(input int g, input logic [127:0] d, input logic inv);
        in_valid[g] = 1'b1;
        in_data[g]  = d;
        in_inv[g]   = inv;
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_out(input int g, output int lat);
        lat = 0;
        while (!out_valid[g] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take(input int g);
        out_ready[g] = 1'b1;
        @(posedge clk); #1;
        out_ready[g] = 1'b0;
    endtask

    task automatic run(input int g, input logic [127:0] d, input logic inv,
                       output logic [127:0] res, output int lat);
        start(g, d, inv);
        wait_out(g, lat);
        res = out_data[g];
        take(g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res;
        logic [127:0] mid;
        logic [127:0] rnd;
        int           lat;
        int           seen;

        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            in_valid[g] = 1'b0; in_data[g] = '0; in_inv[g] = 1'b0; out_ready[g] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_in_ready%0d", g),  in_ready[g],  1'b1);
            check($sformatf("rst_busy%0d", g),      busy[g],      1'b0);
            check($sformatf("rst_out_valid%0d", g), out_valid[g], 1'b0);
            check($sformatf("rst_out_data%0d", g),  out_data[g],  128'h0);
        end

        for (int g = 0; g < 3; g++) begin
            run(g, FWD_IN, 1'b0, res, lat);
            check($sformatf("fwd_data%0d", g), res, FWD_OUT);
            check($sformatf("fwd_lat%0d", g), lat, 4 >> g);
            check($sformatf("post_ready%0d", g), in_ready[g], 1'b1);
            run(g, V2_IN, 1'b0, res, lat);
            check($sformatf("fwd2_data%0d", g), res, V2_OUT);
            check($sformatf("fwd2_lat%0d", g), lat, 4 >> g);
        end

`ifdef MIX_COL_ENGINE_INV_EN
        for (int g = 0; g < 3; g++) begin
            run(g, FWD_OUT, 1'b1, res, lat);
            check($sformatf("inv_data%0d", g), res, FWD_IN);
        end
        for (int i = 0; i < 100; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            run(i % 3, rnd, 1'b0, mid, lat);
            run(i % 3, mid, 1'b1, res, lat);
            check($sformatf("round_trip%0d", i), res, rnd);
        end
`else
        for (int g = 0; g < 3; g++) begin
            run(g, FWD_IN, 1'b1, res, lat);
            check($sformatf("noinv_data%0d", g), res, FWD_OUT);
        end
`endif

        // Backpressure: result held with out_ready low, extra in_valid ignored.
        start(0, FWD_IN, 1'b0);
        wait_out(0, lat);
        check("bp_lat", lat, 4);
        in_valid[0] = 1'b1;
        in_data[0]  = V2_IN;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), out_valid[0], 1'b1);
            check($sformatf("bp_data%0d", i),  out_data[0],  FWD_OUT);
            check($sformatf("bp_ready%0d", i), in_ready[0],  1'b0);
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        take(0);
        check("bp_rel_valid", out_valid[0], 1'b0);
        check("bp_rel_ready", in_ready[0],  1'b1);
        check("bp_rel_busy",  busy[0],      1'b0);

        // Inputs wiggling during RUN must not disturb the latched block.
        start(0, FWD_IN, 1'b0);
        in_valid[0] = 1'b1;
        in_data[0]  = V2_IN;
        in_inv[0]   = 1'b1;
        @(posedge clk); #1;
        in_data[0]  = ~FWD_IN;
        in_inv[0]   = 1'b0;
        @(posedge clk); #1;
        in_inv[0]   = 1'b1;
        wait_out(0, lat);
        in_valid[0] = 1'b0;
        in_inv[0]   = 1'b0;
        check("mid_lat",  lat, 2);
        check("mid_data", out_data[0], FWD_OUT);
        take(0);

        // Reset while RUN at step 1, with out_ready asserted alongside.
        start(0, FWD_IN, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready[0] = 1'b0;
        check("rrun_valid", out_valid[0], 1'b0);
        check("rrun_busy",  busy[0],      1'b0);
        check("rrun_ready", in_ready[0],  1'b1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid[0] || busy[0]) seen = 1;
            @(posedge clk); #1;
        end
        check("rrun_no_out", seen, 0);

        // Reset in DONE coincident with out_ready.
        start(0, V2_IN, 1'b0);
        wait_out(0, lat);
        check("rdone_pre_valid", out_valid[0], 1'b1);
        rst = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready[0] = 1'b0;
        check("rdone_valid", out_valid[0], 1'b0);
        check("rdone_busy",  busy[0],      1'b0);
        check("rdone_ready", in_ready[0],  1'b1);
        check("rdone_data",  out_data[0],  128'h0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid[0] || busy[0]) seen = 1;
            @(posedge clk); #1;
        end
        check("rdone_no_out", seen, 0);

        // Engine still functional after the resets.
        run(0, FWD_IN, 1'b0, res, lat);
        check("after_rst_data", res, FWD_OUT);
        check("after_rst_lat",  lat, 4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mix_col_engine.md
MIX_COL_ENGINE -- requirements
Module: mix_col_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYC, default 1, number of 32-bit state columns transformed per clock; legal values 1, 2, 4.
REQ-002 SHALL have derived localparam NSTEP = 4/COLS_PER_CYC, the clock edges per block.
REQ-003 SHALL have port clk  input  1  rising-edge clock (sole clock).
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  input block present.
REQ-006 SHALL have port in_ready  output  1  engine can accept a block.
REQ-007 SHALL have port in_data  input  128  state block, [0:127] ordering, column c = bits [32c:32c+31], byte r of column = bits [32c+8r:32c+8r+7].
REQ-008 SHALL have port in_inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_data.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_data  output  128  transformed block, same ordering as in_data.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL assert in_ready only in IDLE; accept when in_valid && in_ready; latch in_data and in_inv; clear step counter; go to RUN.
REQ-015 SHALL, on each RUN edge, replace columns [step*COLS_PER_CYC .. step*COLS_PER_CYC+COLS_PER_CYC-1] of the held block with their transform and increment step.
REQ-016 SHALL leave RUN for DONE on the edge at which step = NSTEP-1 is processed; out_valid rises exactly NSTEP edges after the accepting edge.
REQ-017 SHALL use forward matrix rows {02 03 01 01} rotated, inverse rows {0e 0b 0d 09} rotated, GF(2^8) reduction polynomial 0x11b, all bytes 8-bit with no carry-out.
REQ-018 SHALL hold out_valid and out_data stable in DONE until out_ready; on out_valid && out_ready, go to IDLE.
REQ-019 SHALL NOT accept a new block in the cycle of the output handshake, since in_ready is low in DONE; the earliest next accept is the following edge.
REQ-020 SHALL ignore in_valid, in_data and in_inv changes while busy, with the latched mode governing the whole block.
REQ-021 SHALL drive out_data only from the result register; value is undefined-but-stable outside DONE.

Reset
REQ-022 SHALL, on rst high at a clock edge, go to IDLE, set step=0, out_valid=0, busy=0, in_ready=1 after that edge, and clear the data register to zero.
REQ-023 SHALL let rst win over any simultaneous handshake; a block in RUN or DONE is discarded without output.

Configuration
REQ-024 SHALL compile the inverse datapath only when macro MIX_COL_ENGINE_INV_EN is defined.
REQ-025 SHALL, without MIX_COL_ENGINE_INV_EN, ignore in_inv and always apply the forward transform, with no inverse multipliers synthesised.

Structure
REQ-026 SHALL place the xtime and gf_mul functions, the polynomial constant 8'h1b, and the FSM state enum in package mix_col_pkg.
REQ-027 SHALL instantiate sub-module mix_col_unit (one 32-bit column, combinational, inv select) COLS_PER_CYC times via generate.

Verification
REQ-028 SHALL check forward column db 13 53 45 -> 8e 4d a1 bc, f2 0a 22 5c -> 9f dc 58 9d, d4 d4 d4 d5 -> d5 d5 d7 d6, c6 c6 c6 c6 unchanged, in one block for each COLS_PER_CYC in {1,2,4}, with out_valid at exactly 4, 2 and 1 edges respectively.
REQ-029 SHALL check inverse with in_inv=1 on 8e4da1bc 9fdc589d d5d5d7d6 c6c6c6c6 -> db135345 f20a225c d4d4d4d5 c6c6c6c6; also check forward-then-inverse round trip of 100 random blocks.
REQ-030 SHALL check backpressure: out_ready low 5 cycles -> out_valid, out_data stable, in_ready 0; then out_ready=1 -> IDLE next edge, in_ready=1.
REQ-031 SHALL check mid-block changes: toggle in_inv and in_data during RUN -> result matches the originally latched block and mode.
REQ-032 SHALL check reset in RUN (step 1, COLS_PER_CYC=1) and in DONE -> next cycle out_valid=0, busy=0, in_ready=1, no output handshake occurs.
REQ-033 SHALL check a build without MIX_COL_ENGINE_INV_EN: in_inv=1 on db135345 column -> 8e4da1bc.
